turbo_encoder: RTL and testbench
================================

Name: turbo_encoder

Overview:
Rate-1/3 parallel-concatenated (turbo) encoder, the transmit-side counterpart of the team's turbo decoder.
- Accepts one FRAME_LEN-bit frame and encodes it with two identical recursive systematic convolutional (RSC) encoders, the second fed through a fixed interleaver.
- Emits one 8-bit symbol per accepted handshake, each carrying {systematic, parity1, parity2}, on a byte interface matching the decoder's i_data width.
- Sits between the frame source and the channel/decoder test path.

Parameters:
- FRAME_LEN, 16, bits per frame; must be a power of two.
- INTLV_A, 5, interleaver multiplier; must be odd.
- INTLV_B, 3, interleaver offset.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_start  input  1  frame-start request; sampled only in IDLE.
- i_frame  input  FRAME_LEN  frame bits; u_i = i_frame[FRAME_LEN-1-i], so the MSB is sent first.
- i_ready  input  1  downstream ready.
- o_busy  output  1  high from start acceptance until the last symbol is handshaken.
- o_valid  output  1  symbol valid.
- o_data  output  8  {5'b0, sys, par1, par2}.
- o_sof  output  1  high with the first symbol of a frame.
- o_eof  output  1  high with the last symbol of a frame.

Behaviour:
- Reset: synchronous, active-low, one clock, single domain. All outputs go to 0, the FSM goes to IDLE, both RSC states are cleared and the latched frame is cleared. Reset asserted mid-frame aborts the frame immediately with no eof.
- FSM states: IDLE -> DATA (FRAME_LEN symbols) -> TAIL1 (2 symbols) -> TAIL2 (2 symbols) -> IDLE. Total FRAME_LEN+4 = 20 symbols.
- Start acceptance:
  - In IDLE, i_start=1 latches i_frame, clears the step counter and both RSC states, and enters DATA.
  - The first symbol appears with o_valid=1 and o_sof=1 on the next cycle (latency 1).
  - i_start outside IDLE is ignored, including on the eof handshake cycle.
- Handshake:
  - A symbol transfers when o_valid && i_ready.
  - While o_valid && !i_ready, o_data, o_sof and o_eof hold stable and the RSC states do not advance.
  - After the eof transfer: o_valid=0, o_busy=0, state IDLE. A new start can be accepted on the following cycle.
- RSC encoder, generators (7,5) octal, state {s1,s0}:
  - Feedback a = u^s1^s0.
  - Parity p = a^s0.
  - Next state {a, s1}.
- Interleaver: pi(i) = (INTLV_A*i + INTLV_B) mod FRAME_LEN. At step i, encoder 1 takes u_i and encoder 2 takes u_pi(i).
- DATA step i (i = 0..FRAME_LEN-1): sys=u_i, par1=p(enc1), par2=p(enc2).
- TAIL1 (enc1 terminates, enc2 held):
  - Tail input t = s1^s0, which forces a=0.
  - Output sys=t, par1=s0, par2=0.
- TAIL2 (enc2 terminates, enc1 held): same rule applied to enc2; sys=t2, par1=0, par2=s0 of enc2.
- Termination: after TAIL2 both encoder states are 00.
- o_data[7:3] is always 0.

Optional Feature:
PUNCTURE_EN: rate-1/2 puncturing during DATA only.
- When defined:
  - o_data[1] carries par1 on even steps and par2 on odd steps.
  - o_data[0] is forced to 0.
  - Symbol count and tail symbols are unchanged.
- When undefined: unpunctured rate-1/3 output as specified above.

Decomposition:
- Package turbo_pkg holds:
  - FSM state enum {IDLE, DATA, TAIL1, TAIL2}.
  - TAIL_LEN=2 and the symbol bit-position constants.
  - Function intlv(i), the interleaver mapping.
- Sub-module rsc_encoder, instantiated twice:
  - Ports: i_clk, i_rst_n, i_clr, i_en, i_tail, i_bit, o_sys, o_par.
  - Outputs are combinational from the current state and input; state advances on i_en.

Test Plan:
- All-zero frame 16'h0000, i_ready=1 -> 20 symbols, all 8'h00; sof on symbol 0; eof on symbol 19; o_busy falls after symbol 19.
- Impulse frame 16'h8000 -> symbols 0..2 have par1=1,1,1; sys=1 only at symbol 0; par2=1 first at symbol 9 (pi(9)=0); both encoder states are 00 after TAIL2.
- Random frame 16'hF2CF with i_ready toggling every other cycle -> symbol stream identical to the i_ready=1 run; o_data stable across every stall cycle.
- i_start pulsed during DATA and on the eof handshake cycle -> ignored; a new start the cycle after eof -> accepted, and the next sof follows with latency 1.
- i_rst_n=0 at symbol 7 -> next cycle all outputs 0 and state IDLE; a following frame 16'h0000 encodes cleanly with no residue from the aborted frame.
- PUNCTURE_EN build with frame 16'h8000 -> o_data[0]=0 throughout DATA; symbols 0 and 2 carry par1=1 in bit 1.

Source files
------------

// File: rtl/turbo_encoder_pkg.sv
// Shared types and constants for the rate-1/3 turbo encoder.
// Build option: define PUNCTURE_EN for rate-1/2 puncturing during DATA.
package turbo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL1,
    TAIL2
  } state_e;

  localparam int TAIL_LEN = 2;

  // Bit positions of the three code bits inside o_data.
  localparam int SYS_BIT  = 2;
  localparam int PAR1_BIT = 1;
  localparam int PAR2_BIT = 0;

  function automatic int intlv(input int i, input int a, input int b, input int len);
    return (a * i + b) % len;
  endfunction

endpackage

// File: rtl/turbo_encoder_if.sv
// Frame-in / symbol-out bus of the turbo encoder.
// The encoder uses the slave modport; the frame source and sink use master.
interface turbo_encoder_if #(
  parameter int FRAME_LEN = 16
);
  logic                 i_start;
  logic [FRAME_LEN-1:0] i_frame;
  logic                 i_ready;
  logic                 o_busy;
  logic                 o_valid;
  logic [7:0]           o_data;
  logic                 o_sof;
  logic                 o_eof;

  modport master (
    output i_start, i_frame, i_ready,
    input  o_busy, o_valid, o_data, o_sof, o_eof
  );

  modport slave (
    input  i_start, i_frame, i_ready,
    output o_busy, o_valid, o_data, o_sof, o_eof
  );
endinterface

// File: rtl/turbo_encoder_rsc.sv
// Recursive systematic convolutional encoder, generators (7,5) octal.
// Outputs are combinational from state and input; i_tail drives the input that zeroes feedback.
module rsc_encoder (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_tail,
  input  logic i_bit,
  output logic o_sys,
  output logic o_par
);

  logic [1:0] state;  // {s1, s0}
  logic       u;
  logic       a;

  always_comb begin
    u = i_tail ? (state[1] ^ state[0]) : i_bit;
    a = u ^ state[1] ^ state[0];
  end

  assign o_sys = u;
  assign o_par = a ^ state[0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      state <= '0;
    end else if (i_en) begin
      state <= {a, state[1]};
    end
  end

endmodule

// File: rtl/turbo_encoder.sv
// Rate-1/3 turbo encoder: two (7,5) RSC encoders, the second fed through pi(i) = (A*i+B) mod N.
// Build option: PUNCTURE_EN selects rate-1/2 puncturing of the parity bits during DATA.
module turbo_encoder
  import turbo_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int INTLV_A   = 5,
  parameter int INTLV_B   = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  turbo_encoder_if.slave  bus
);

  localparam int IDX_W = $clog2(FRAME_LEN);

  state_e               state, state_d;
  logic [IDX_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     pi_idx;
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic                 start, fire;
  logic                 en1, en2;
  logic                 sys1, par1, sys2, par2;
  logic [7:0]           data;

  assign fire   = (state != IDLE) && bus.i_ready;
  assign pi_idx = IDX_W'(intlv(int'(cnt), INTLV_A, INTLV_B, FRAME_LEN));
  assign en1    = fire && (state == DATA || state == TAIL1);
  assign en2    = fire && (state == DATA || state == TAIL2);

  // FRAME_LEN is a power of two, so FRAME_LEN-1-i is simply ~i: MSB goes first.
  rsc_encoder u_enc1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (start),
    .i_en    (en1),
    .i_tail  (state == TAIL1),
    .i_bit   (frame_q[~cnt]),
    .o_sys   (sys1),
    .o_par   (par1)
  );

  rsc_encoder u_enc2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (start),
    .i_en    (en2),
    .i_tail  (state == TAIL2),
    .i_bit   (frame_q[~pi_idx]),
    .o_sys   (sys2),
    .o_par   (par2)
  );

  // NOTE: the frame latch is an ordinary register, not a memory, so it is cleared by reset too.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      frame_q <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    frame_d = frame_q;
    start   = 1'b0;
    case (state)
      IDLE: if (bus.i_start) begin
        start   = 1'b1;
        frame_d = bus.i_frame;
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: if (fire) begin
        if (cnt == IDX_W'(FRAME_LEN - 1)) begin
          cnt_d   = '0;
          state_d = TAIL1;
        end else begin
          cnt_d = cnt + IDX_W'(1);
        end
      end
      TAIL1, TAIL2: if (fire) begin
        if (cnt == IDX_W'(TAIL_LEN - 1)) begin
          cnt_d   = '0;
          state_d = (state == TAIL1) ? TAIL2 : IDLE;
        end else begin
          cnt_d = cnt + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Each tail drives the terminating encoder with a=0, so its parity equals s0.
  always_comb begin
    data = '0;
    case (state)
      DATA: begin
        data[SYS_BIT] = sys1;
`ifdef PUNCTURE_EN
        data[PAR1_BIT] = cnt[0] ? par2 : par1;
`else
        data[PAR1_BIT] = par1;
        data[PAR2_BIT] = par2;
`endif
      end
      TAIL1: begin
        data[SYS_BIT]  = sys1;
        data[PAR1_BIT] = par1;
      end
      TAIL2: begin
        data[SYS_BIT]  = sys2;
        data[PAR2_BIT] = par2;
      end
      default: data = '0;
    endcase
  end

  assign bus.o_busy  = (state != IDLE);
  assign bus.o_valid = (state != IDLE);
  assign bus.o_data  = data;
  assign bus.o_sof   = (state == DATA) && (cnt == '0);
  assign bus.o_eof   = (state == TAIL2) && (cnt == IDX_W'(TAIL_LEN - 1));

endmodule

// File: tb/tb_turbo_encoder.sv
// Self-checking bench for turbo_encoder: a frame model fills a scoreboard, a negedge monitor pops it.
// Honours PUNCTURE_EN the same way the design does.
module tb_turbo_encoder;
  import turbo_pkg::*;

  localparam int FL   = 16;
  localparam int NSYM = FL + 2 * TAIL_LEN;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } sym_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  turbo_encoder_if #(.FRAME_LEN(FL)) bus ();

  turbo_encoder #(
    .FRAME_LEN (FL),
    .INTLV_A   (5),
    .INTLV_B   (3)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int         errors = 0;
  int         checks = 0;
  sym_t       sb[$];
  logic [7:0] rx[NSYM];
  logic [7:0] ref_rx[NSYM];
  int         rx_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder built straight from the RSC and interleaver equations.
  function automatic void push_frame(input logic [FL-1:0] f);
    logic s1a, s0a, s1b, s0b, u, v, a, b, p1, p2, t;
    logic [7:0] d;
    s1a = 0; s0a = 0; s1b = 0; s0b = 0;
    for (int i = 0; i < FL; i++) begin
      u = f[FL-1-i];
      v = f[FL-1-((5*i+3) % FL)];
      a = u ^ s1a ^ s0a; p1 = a ^ s0a; s0a = s1a; s1a = a;
      b = v ^ s1b ^ s0b; p2 = b ^ s0b; s0b = s1b; s1b = b;
`ifdef PUNCTURE_EN
      d = {5'b0, u, (i % 2 == 0) ? p1 : p2, 1'b0};
`else
      d = {5'b0, u, p1, p2};
`endif
      sb.push_back('{data: d, sof: (i == 0), eof: 1'b0});
    end
    for (int k = 0; k < TAIL_LEN; k++) begin
      t = s1a ^ s0a; p1 = s0a; s0a = s1a; s1a = 1'b0;
      sb.push_back('{data: {5'b0, t, p1, 1'b0}, sof: 1'b0, eof: 1'b0});
    end
    for (int k = 0; k < TAIL_LEN; k++) begin
      t = s1b ^ s0b; p2 = s0b; s0b = s1b; s1b = 1'b0;
      sb.push_back('{data: {5'b0, t, 1'b0, p2}, sof: 1'b0, eof: (k == TAIL_LEN - 1)});
    end
  endfunction

  // Monitor: handshakes are judged at the negedge before the transferring posedge.
  initial begin
    logic prev_stall = 1'b0;
    logic post_eof   = 1'b0;
    sym_t prev_sym   = '0;
    sym_t exp_sym;
    forever begin
      @(negedge clk);
      if (post_eof) begin
        check("busy_after_eof", bus.o_busy, 0);
        check("valid_after_eof", bus.o_valid, 0);
      end
      if (prev_stall) begin
        check("stall_valid", bus.o_valid, 1);
        check("stall_hold", {bus.o_data, bus.o_sof, bus.o_eof}, prev_sym);
      end
      post_eof = 1'b0;
      if (bus.o_valid && bus.i_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_sym = sb.pop_front();
          check("sym_data", bus.o_data, exp_sym.data);
          check("sym_sof", bus.o_sof, exp_sym.sof);
          check("sym_eof", bus.o_eof, exp_sym.eof);
        end
        if (rx_cnt < NSYM) rx[rx_cnt] = bus.o_data;
        rx_cnt++;
        post_eof = bus.o_eof;
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_sym   = '{bus.o_data, bus.o_sof, bus.o_eof};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [FL-1:0] f);
    rx_cnt = 0;
    push_frame(f);
    bus.i_frame = f;
    bus.i_start = 1'b1;
    cycle();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    int n = 0;
    while (bus.o_busy && n < 300) begin
      if (toggle) bus.i_ready = ~bus.i_ready;
      cycle();
      n++;
    end
    check("frame_timeout", n < 300, 1);
    bus.i_ready = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_valid"}, bus.o_valid, 0);
    check({tag, "_data"}, bus.o_data, 0);
    check({tag, "_sof_eof"}, {bus.o_sof, bus.o_eof}, 0);
    check({tag, "_state"}, dut.state, IDLE);
  endtask

  task automatic check_terminated(input string tag);
    check({tag, "_enc1_state"}, dut.u_enc1.state, 0);
    check({tag, "_enc2_state"}, dut.u_enc2.state, 0);
  endtask

  initial begin
    logic [7:0] acc;
    int         first, nsys, n;

    bus.i_start = 1'b0;
    bus.i_frame = '0;
    bus.i_ready = 1'b1;
    rst_n       = 1'b0;
    repeat (3) cycle();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    cycle();

    // All-zero frame.
    start_frame(16'h0000);
    check("zero_sof_latency", {bus.o_valid, bus.o_sof, bus.o_busy}, 3'b111);
    wait_done(0);
    check("zero_count", rx_cnt, NSYM);
    acc = '0;
    for (int i = 0; i < NSYM; i++) acc |= rx[i];
    check("zero_all_symbols", acc, 0);

    // Impulse frame.
    start_frame(16'h8000);
    wait_done(0);
    check("imp_count", rx_cnt, NSYM);
    nsys = 0;
    for (int i = 0; i < FL; i++) nsys += int'(rx[i][2]);
    check("imp_sys_only_sym0", {rx[0][2], 27'(nsys)}, {1'b1, 27'd1});
`ifdef PUNCTURE_EN
    check("punct_sym0_par1", rx[0][1], 1);
    check("punct_sym2_par1", rx[2][1], 1);
    acc = '0;
    for (int i = 0; i < FL; i++) acc[0] |= rx[i][0];
    check("punct_bit0_zero", acc[0], 0);
`else
    check("imp_par1_first3", {rx[0][1], rx[1][1], rx[2][1]}, 3'b111);
    first = -1;
    for (int i = 0; i < FL; i++) if (rx[i][0] && first < 0) first = i;
    check("imp_first_par2", first, 9);
`endif
    check_terminated("imp");

    // Same random frame with ready held high, then toggling.
    start_frame(16'hF2CF);
    wait_done(0);
    for (int i = 0; i < NSYM; i++) ref_rx[i] = rx[i];
    start_frame(16'hF2CF);
    wait_done(1);
    check("stall_count", rx_cnt, NSYM);
    for (int i = 0; i < NSYM; i++) check("stall_stream", rx[i], ref_rx[i]);

    // Stray starts during DATA and on the eof handshake are ignored.
    start_frame(16'h1357);
    repeat (4) cycle();
    bus.i_frame = 16'hFFFF;
    bus.i_start = 1'b1;
    cycle();
    bus.i_start = 1'b0;
    n = 0;
    while (!bus.o_eof && n < 100) begin
      cycle();
      n++;
    end
    check("eof_timeout", n < 100, 1);
    bus.i_frame = 16'hAAAA;
    bus.i_start = 1'b1;
    cycle();
    check("eof_start_ignored", {bus.o_busy, bus.o_valid}, 2'b00);
    check("pulse_count", rx_cnt, NSYM);
    rx_cnt = 0;
    push_frame(16'h2468);
    bus.i_frame = 16'h2468;
    cycle();
    bus.i_start = 1'b0;
    check("restart_sof_latency", {bus.o_valid, bus.o_sof}, 2'b11);
    wait_done(0);
    check("restart_count", rx_cnt, NSYM);

    // Reset at symbol 7, then a clean all-zero frame.
    start_frame(16'hF2CF);
    n = 0;
    while (rx_cnt < 7 && n < 100) begin
      cycle();
      n++;
    end
    check("sym7_timeout", n < 100, 1);
    rst_n = 1'b0;
    cycle();
    sb.delete();
    check_idle_outputs("midreset");
    check_terminated("midreset");
    rst_n = 1'b1;
    cycle();
    start_frame(16'h0000);
    wait_done(0);
    check("post_reset_count", rx_cnt, NSYM);
    acc = '0;
    for (int i = 0; i < NSYM; i++) acc |= rx[i];
    check("post_reset_zero", acc, 0);
    check_terminated("post_reset");
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
